alu_muldiv_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 63 ++++++
 rtl/muldiv_iter.sv | 91 +++++++++
 rtl/alu_muldiv_seq.sv | 172 +++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential execute ALU: op codes, FSM states
// and small op-classification helpers used by the datapath and the FSM.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_XOR    = 5'd2,
    OP_OR     = 5'd3,
    OP_AND    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_MUL    = 5'd10,
    OP_MULH   = 5'd11,
    OP_MULHSU = 5'd12,
    OP_MULHU  = 5'd13,
    OP_DIV    = 5'd14,
    OP_DIVU   = 5'd15,
    OP_REM    = 5'd16,
    OP_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } alu_state_e;

  // Any op that goes through the iterative engine.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= 5'd10) && (op <= 5'd17);
  endfunction

  // Divide and remainder ops.
  function automatic logic is_divrem(input logic [4:0] op);
    return (op >= 5'd14) && (op <= 5'd17);
  endfunction

  // Operand A is treated as two's complement.
  function automatic logic is_signed_a(input logic [4:0] op);
    logic s;
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: s = 1'b1;
      default:                                   s = 1'b0;
    endcase
    return s;
  endfunction

  // Operand B is treated as two's complement.
  function automatic logic is_signed_b(input logic [4:0] op);
    logic s;
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: s = 1'b1;
      default:                         s = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply / restoring divide engine. Works on operand
// magnitudes; sign correction is done by the caller afterwards.
// Multiply: {acc, shreg} holds the running product, shreg starts as the
// multiplier. Divide: acc is the partial remainder, shreg shifts the
// dividend out and the quotient bits in.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic             fast,
  input  logic             is_div,
  input  logic             step,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic             last,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] shreg
);

  logic [WIDTH-1:0] opnd;
  logic             div_mode;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] acc_n;
  logic [WIDTH-1:0] shreg_n;
  logic             carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;

  assign last = (cnt == CNT_W'(1));

  // One shift-add or shift-subtract step, chosen by the latched mode.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    acc_n   = acc;
    shreg_n = shreg;
    {carry, sum} = {1'b0, acc} + {1'b0, (shreg[0] ? opnd : '0)};
    rem_sh  = {acc, shreg[WIDTH-1]};
    rem_ge  = (rem_sh >= {1'b0, opnd});
    rem_sub = rem_sh[WIDTH-1:0] - opnd;
    if (div_mode) begin
      acc_n   = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
      shreg_n = {shreg[WIDTH-2:0], rem_ge};
    end else begin
      acc_n   = {carry, sum[WIDTH-1:1]};
      shreg_n = {sum[0], shreg[WIDTH-1:1]};
    end
  end

  // Operand load on start, one iteration per step while the counter runs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge.
    if (!rst_n) begin
      acc      <= '0;
      shreg    <= '0;
      opnd     <= '0;
      div_mode <= 1'b0;
      cnt      <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      div_mode <= is_div;
      if (fast) begin
        // Result is known without iterating: quotient all-ones (b == 0) or
        // zero (|a| < |b|), remainder is the dividend magnitude.
        acc   <= mag_a;
        shreg <= (mag_b == '0) ? '1 : '0;
        opnd  <= mag_b;
        cnt   <= '0;
      end else begin
        acc   <= '0;
        shreg <= is_div ? mag_a : mag_b;
        opnd  <= is_div ? mag_b : mag_a;
        cnt   <= CNT_W'(WIDTH);
      end
    end else if (step && (cnt != '0)) begin
      acc   <= acc_n;
      shreg <= shreg_n;
      cnt   <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Registered EX-stage ALU with valid/ready handshake and an iterative
// RV32M-style multiply/divide engine. Simple ops take one cycle, mul/div
// take WIDTH+2 cycles.
// Optional: define ALU_DIV_FAST_PATH_EN to let div/rem by zero, or with
// |a| < |b|, skip the iteration (IDLE -> FIX -> DONE).
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SH_W  = $clog2(WIDTH);

  alu_state_e state, state_n, accept_target;

  alu_op_e op_q;
  logic    neg_a_q, neg_b_q, b_zero_q;

  logic             accept;
  logic             op_md, op_div, fast;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] simple_res;
  logic [WIDTH-1:0] fix_res;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo, rem;

  logic             it_last;
  logic [WIDTH-1:0] it_acc, it_shreg;

  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_CALC) || (state == ST_FIX);

  assign op_md  = is_muldiv(op);
  assign op_div = is_divrem(op);
  assign neg_a  = is_signed_a(op) && src_a[WIDTH-1];
  assign neg_b  = is_signed_b(op) && src_b[WIDTH-1];
  assign mag_a  = neg_a ? -src_a : src_a;
  assign mag_b  = neg_b ? -src_b : src_b;
  assign shamt  = src_b[SH_W-1:0];

`ifdef ALU_DIV_FAST_PATH_EN
  assign fast = op_div && ((src_b == '0) || (mag_a < mag_b));
`else
  assign fast = 1'b0;
`endif

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (flush),
    .start  (accept && op_md),
    .fast   (fast),
    .is_div (op_div),
    .step   (state == ST_CALC),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .last   (it_last),
    .acc    (it_acc),
    .shreg  (it_shreg)
  );

  // Single-cycle ops; unused codes give zero.
  always_comb begin
    simple_res = '0;
    case (op)
      OP_ADD:  simple_res = src_a + src_b;
      OP_SUB:  simple_res = src_a - src_b;
      OP_XOR:  simple_res = src_a ^ src_b;
      OP_OR:   simple_res = src_a | src_b;
      OP_AND:  simple_res = src_a & src_b;
      OP_SLL:  simple_res = src_a << shamt;
      OP_SRL:  simple_res = src_a >> shamt;
      OP_SRA:  simple_res = $signed(src_a) >>> shamt;
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: simple_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      default: simple_res = '0;
    endcase
  end

  // Sign correction and half selection of the engine output.
  always_comb begin
    prod     = {it_acc, it_shreg};
    prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
    // Division by zero always yields all ones, whatever the operand signs.
    quo      = b_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -it_shreg : it_shreg);
    // Remainder takes the sign of the dividend.
    rem      = neg_a_q ? -it_acc : it_acc;
    fix_res  = '0;
    case (op_q)
      OP_MUL:                       fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:              fix_res = quo;
      OP_REM, OP_REMU:              fix_res = rem;
      default:                      fix_res = '0;
    endcase
  end

  // Where an accepted op goes first.
  always_comb begin
    if (!op_md)    accept_target = ST_DONE;
    else if (fast) accept_target = ST_FIX;
    else           accept_target = ST_CALC;
  end

  // Next-state logic; flush wins over accept and out_ready.
  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (accept) state_n = accept_target;
        ST_CALC: if (it_last) state_n = ST_FIX;
        ST_FIX:  state_n = ST_DONE;
        ST_DONE: if (out_ready) state_n = accept ? accept_target : ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Op/sign capture on accept; result and zero registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_ADD;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      b_zero_q <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
    end else if (accept) begin
      op_q     <= alu_op_e'(op);
      neg_a_q  <= neg_a;
      neg_b_q  <= neg_b;
      b_zero_q <= (src_b == '0);
      if (!op_md) begin
        result <= simple_res;
        zero   <= (simple_res == '0);
      end
    end else if ((state == ST_FIX) && !flush) begin
      result <= fix_res;
      zero   <= (fix_res == '0);
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq (WIDTH = 32). A behavioural model
// using 64-bit arithmetic predicts every result and its latency; a single
// compare process checks each cycle out_valid is high.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [4:0]    op_i;
  logic [W-1:0]  a_i, b_i, result;

  alu_muldiv_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op_i),
    .src_a     (a_i),
    .src_b     (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] exp;
    int           lat;
    int           acc_edge;
    bit           seen;
  } item_t;

  item_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int last_acc = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the architectural definition.
  function automatic logic [W-1:0] model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint     sa, sb_, ua, ub, p;
    logic [63:0] up;
    logic [W-1:0] r;
    sa = longint'($signed(a));
    sb_ = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r  = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a ^ b;
      5'd3:  r = a | b;
      5'd4:  r = a & b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  r = $signed(a) >>> b[4:0];
      5'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9:  r = (a < b) ? 32'd1 : 32'd0;
      5'd10: begin p = sa * sb_; r = p[31:0];  end
      5'd11: begin p = sa * sb_; r = p[63:32]; end
      5'd12: begin p = sa * ub;  r = p[63:32]; end
      5'd13: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      5'd14: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else begin p = sa / sb_; r = p[31:0]; end
      end
      5'd15: r = (b == 0) ? '1 : a / b;
      5'd16: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin p = sa % sb_; r = p[31:0]; end
      end
      5'd17: begin
        if (b == 0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Cycles from accept to first out_valid.
  function automatic int lat_of(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (op < 5'd10 || op > 5'd17) return 1;
`ifdef ALU_DIV_FAST_PATH_EN
    if (op >= 5'd14) begin
      logic sgn;
      logic [W-1:0] ma, mb;
      sgn = (op == 5'd14) || (op == 5'd16);
      ma  = (sgn && a[W-1]) ? -a : a;
      mb  = (sgn && b[W-1]) ? -b : b;
      if (b == 0 || ma < mb) return 2;
    end
`endif
    return W + 2;
  endfunction

  // Compare process: every cycle with out_valid, check against the model.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        sb_q.delete();
        continue;
      end
      if (out_valid) begin
        check("busy_low_when_valid", {31'b0, busy}, 32'd0);
        if (sb_q.size() == 0) begin
          check("out_valid_unexpected", {31'b0, out_valid}, 32'd0);
        end else begin
          if (!sb_q[0].seen) begin
            check($sformatf("latency_op%0d", sb_q[0].op), 32'(edge_n), 32'(sb_q[0].acc_edge + sb_q[0].lat - 1));
            sb_q[0].seen = 1'b1;
          end
          check($sformatf("result_op%0d", sb_q[0].op), result, sb_q[0].exp);
          check($sformatf("zero_op%0d", sb_q[0].op), {31'b0, zero}, {31'b0, (sb_q[0].exp == '0)});
          if (out_ready && !flush) begin
            void'(sb_q.pop_front());
            n_xfer++;
          end
        end
      end
      if (flush) sb_q.delete();
    end
  end

  task automatic send(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    item_t it;
    @(negedge clk);
    op_i = op; a_i = a; b_i = b; in_valid = 1'b1;
    #1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", {31'b0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    it.op = op; it.exp = model(op, a, b); it.lat = lat_of(op, a, b);
    it.acc_edge = edge_n; it.seen = 1'b0;
    sb_q.push_back(it);
    last_acc = edge_n;
    in_valid = 1'b0;
  endtask

  // Pins the model to a hand-computed value, then issues the op.
  task automatic send_lit(input string nm, input logic [4:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] lit);
    check({"model_", nm}, model(op, a, b), lit);
    send(op, a, b);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e1, k, x0, e_div;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op_i = '0; a_i = '0; b_i = '0;

    // Reset state.
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'b0, zero}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Simple ops, back to back.
    send_lit("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
    e1 = last_acc;
    send_lit("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    check("b2b_accept_edge", 32'(last_acc), 32'(e1 + 1));
    send(OP_XOR, 32'hF0F0_1234, 32'h0FF0_FFFF);
    send(OP_OR,  32'h0000_00F0, 32'h0000_000F);
    send(OP_AND, 32'hFFFF_0000, 32'h00FF_FF00);
    send_lit("sll", OP_SLL, 32'h1, 32'h23, 32'h8);
    send_lit("srl", OP_SRL, 32'h8000_0000, 32'h4, 32'h0800_0000);
    send_lit("sra", OP_SRA, 32'h8000_0000, 32'h4, 32'hF800_0000);
    send_lit("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1);
    send_lit("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0);
    send(5'd20, 32'h1234, 32'h5678);
    wait_drain(20);

    // Multiply.
    send_lit("mulh", OP_MULH, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF);
    send_lit("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'h2, 32'h1);
    send_lit("mul", OP_MUL, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE);
    send_lit("mulhsu_a", OP_MULHSU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF);
    send_lit("mulhsu_b", OP_MULHSU, 32'h2, 32'hFFFF_FFFF, 32'h1);
    send(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_drain(100);

    // Divide / remainder, including the corner cases.
    send_lit("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD);
    send_lit("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF);
    send_lit("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    send_lit("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    send_lit("divu_z", OP_DIVU, 32'h5, 32'h0, 32'hFFFF_FFFF);
    send_lit("rem_z", OP_REM, 32'h5, 32'h0, 32'h5);
    send_lit("div_negz", OP_DIV, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFF);
    send_lit("remu", OP_REMU, 32'd100, 32'd7, 32'd2);
    send_lit("divu", OP_DIVU, 32'd100, 32'd7, 32'd14);
    send_lit("div_small", OP_DIV, 32'd3, 32'hFFFF_FFF6, 32'd0);
    send_lit("rem_small", OP_REM, 32'd3, 32'hFFFF_FFF6, 32'd3);
    wait_drain(100);

    // Backpressure: result held, no acceptance, exactly one transfer.
    @(negedge clk);
    out_ready = 1'b0;
    send(OP_SUB, 32'd3, 32'd3);
    k = 0;
    while (!out_valid && k < 10) begin
      @(negedge clk);
      #3;
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3;
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_result", result, 32'd0);
      check("bp_zero", {31'b0, zero}, 32'd1);
      check("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    x0 = n_xfer;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    check("bp_single_transfer", 32'(n_xfer - x0), 32'd1);
    check("bp_released", {31'b0, out_valid}, 32'd0);

    // Flush ten cycles into a DIVU, with a competing op that must be ignored.
    send(OP_DIVU, 32'd1000, 32'd3);
    e_div = last_acc;
    while (edge_n < e_div + 9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    #1;
    check("busy_in_calc", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    in_valid = 1'b1; op_i = OP_ADD; a_i = 32'd1; b_i = 32'd1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    repeat (45) @(posedge clk);
    #1;
    check("flush_no_result", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of CALC.
    send(OP_ADD, 32'd1, 32'd1);
    wait_drain(10);
    send(OP_MUL, 32'd3, 32'd5);
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_zero", {31'b0, zero}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_lit("mul_after_rst", OP_MUL, 32'd3, 32'd5, 32'd15);
    wait_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
